shift_rows: RTL and testbench

Registered AES ShiftRows stage for the AES-128 encryption datapath, between SubBytes and MixColumns in each round. Takes a 128-bit state on a valid strobe, applies the fixed row-wise byte rotation, and presents the result one clock later with a matching valid. Pure byte permutation, no arithmetic, no stalls, one new state accepted per cycle.

---
 rtl/aes_pkg.sv | 41 ++++
 rtl/shift_rows_perm.sv | 47 ++++
 rtl/shift_rows.sv | 46 ++++
 tb/tb_shift_rows.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES shared types and helpers: byte/state typedefs and conversion between
// the flat 128-bit column-major state vector and the 4x4 byte array s[row][col].
package aes_pkg;

    localparam int AES_STATE_W = 128;

    typedef logic [7:0] aes_byte_t;
    typedef aes_byte_t [0:3][0:3] aes_state_t;

    // Byte k sits at data[127-8k -: 8]; row = k mod 4, column = k div 4.
    function automatic aes_state_t unpack_state(input logic [AES_STATE_W-1:0] v);
        aes_state_t s;
        logic [1:0] row;
        logic [1:0] col;
        logic [6:0] base;
        s = '0;
        for (int k = 0; k < 16; k++) begin
            row  = 2'(k);
            col  = 2'(k >> 2);
            base = 7'(120 - 8 * k);
            s[row][col] = v[base +: 8];
        end
        return s;
    endfunction

    function automatic logic [AES_STATE_W-1:0] pack_state(input aes_state_t s);
        logic [AES_STATE_W-1:0] v;
        logic [1:0] row;
        logic [1:0] col;
        logic [6:0] base;
        v = '0;
        for (int k = 0; k < 16; k++) begin
            row  = 2'(k);
            col  = 2'(k >> 2);
            base = 7'(120 - 8 * k);
            v[base +: 8] = s[row][col];
        end
        return v;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational AES ShiftRows byte permutation (pure wiring).
// With SHIFT_ROWS_INV_EN defined, i_inv selects InvShiftRows instead.
module shift_rows_perm
    import aes_pkg::*;
(
    input  logic [AES_STATE_W-1:0] i_data,
`ifdef SHIFT_ROWS_INV_EN
    input  logic                   i_inv,
`endif
    output logic [AES_STATE_W-1:0] o_data
);

    aes_state_t w_in;
    aes_state_t w_fwd;
`ifdef SHIFT_ROWS_INV_EN
    aes_state_t w_inv;
`endif

    assign w_in = unpack_state(i_data);

    // Row r rotates left by r (forward) or right by r (inverse); 2-bit adds wrap mod 4.
    always_comb begin
        logic [1:0] row;
        logic [1:0] col;
        w_fwd = '0;
`ifdef SHIFT_ROWS_INV_EN
        w_inv = '0;
`endif
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                row = 2'(r);
                col = 2'(c);
                w_fwd[row][col] = w_in[row][col + row];
`ifdef SHIFT_ROWS_INV_EN
                w_inv[row][col] = w_in[row][col - row];
`endif
            end
        end
    end

`ifdef SHIFT_ROWS_INV_EN
    assign o_data = i_inv ? pack_state(w_inv) : pack_state(w_fwd);
`else
    assign o_data = pack_state(w_fwd);
`endif

endmodule

// File: rtl/shift_rows.sv
// Registered AES ShiftRows stage: one state per cycle, 1-cycle latency.
// Optional macro SHIFT_ROWS_INV_EN adds the inv port (InvShiftRows select).
module shift_rows
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [AES_STATE_W-1:0] in_data,
`ifdef SHIFT_ROWS_INV_EN
    input  logic                   inv,
`endif
    output logic                   out_valid,
    output logic [AES_STATE_W-1:0] out_data
);

    logic [AES_STATE_W-1:0] w_perm_p0;
    logic [AES_STATE_W-1:0] r_data_p1;
    logic                   r_vld_p1;

    shift_rows_perm u_perm (
        .i_data (in_data),
`ifdef SHIFT_ROWS_INV_EN
        .i_inv  (inv),
`endif
        .o_data (w_perm_p0)
    );

    // ---- p0 -> p1: valid follows in_valid every cycle; data loads only on valid
    // and otherwise holds. Data is cleared too so reset shows an all-zero state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
        end else begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_data_p1 <= w_perm_p0;
            end
        end
    end

    assign out_valid = r_vld_p1;
    assign out_data  = r_data_p1;

endmodule

// File: tb/tb_shift_rows.sv
// Directed testbench for shift_rows; inverse tests compile only with SHIFT_ROWS_INV_EN.
module tb_shift_rows;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_data;
`ifdef SHIFT_ROWS_INV_EN
    logic         inv;
`endif
    logic         out_valid;
    logic [127:0] out_data;

    int n_checks;
    int n_pass;

    localparam logic [127:0] V_FIPS_IN  = 128'hD42711AEE0BF98F1B8B45DE51E415230;
    localparam logic [127:0] V_FIPS_OUT = 128'hD4BF5D30E0B452AEB84111F11E2798E5;
    localparam logic [127:0] V_IDX_IN   = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] V_IDX_OUT  = 128'h00050A0F04090E03080D02070C01060B;
    localparam logic [127:0] V_PAT_IN   = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] V_PAT_OUT  = 128'h0055AAFF4499EE3388DD2277CC1166BB;
`ifdef SHIFT_ROWS_INV_EN
    localparam logic [127:0] V_IDX_INV  = 128'h000D0A0704010E0B0805020F0C090603;
`endif

    shift_rows dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef SHIFT_ROWS_INV_EN
        .inv       (inv),
`endif
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic vld_exp, input logic [127:0] data_exp);
        n_checks++;
        if (out_valid !== vld_exp) $display("FAIL %s out_valid: got %b want %b", name, out_valid, vld_exp);
        else n_pass++;
        n_checks++;
        if (out_data !== data_exp) $display("FAIL %s out_data: got %h want %h", name, out_data, data_exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = V_FIPS_IN;
`ifdef SHIFT_ROWS_INV_EN
        inv      = 1'b0;
`endif
        #1;
        chk("reset_async", 1'b0, 128'h0);
        cyc();
        cyc();
        chk("reset_held", 1'b0, 128'h0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        cyc();
        chk("reset_release_idle", 1'b0, 128'h0);
    endtask

    task automatic test_forward();
        in_valid = 1'b1;
        in_data  = V_FIPS_IN;
        cyc();
        in_valid = 1'b0;
        chk("fwd_fips", 1'b1, V_FIPS_OUT);
        cyc();
        chk("fwd_fips_drop", 1'b0, V_FIPS_OUT);
    endtask

    task automatic test_index();
        in_valid = 1'b1;
        in_data  = V_IDX_IN;
        cyc();
        in_valid = 1'b0;
        chk("fwd_index", 1'b1, V_IDX_OUT);
        cyc();
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1;
        in_data  = V_FIPS_IN;
        cyc();
        chk("stream_0", 1'b1, V_FIPS_OUT);
        in_data  = V_IDX_IN;
        cyc();
        chk("stream_1", 1'b1, V_IDX_OUT);
        in_data  = V_PAT_IN;
        cyc();
        chk("stream_2", 1'b1, V_PAT_OUT);
        in_valid = 1'b0;
        in_data  = V_IDX_IN;
        cyc();
        chk("stream_end", 1'b0, V_PAT_OUT);
    endtask

    task automatic test_idle();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = {4{$urandom()}};
            cyc();
            chk("idle_hold", 1'b0, V_PAT_OUT);
        end
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1;
        in_data  = V_IDX_IN;
        cyc();
        chk("mid_before", 1'b1, V_IDX_OUT);
        in_data  = V_FIPS_IN;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_clear", 1'b0, 128'h0);
        cyc();
        chk("mid_in_reset", 1'b0, 128'h0);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = V_PAT_IN;
        cyc();
        in_valid = 1'b0;
        chk("mid_first_after", 1'b1, V_PAT_OUT);
        cyc();
        chk("mid_after_drop", 1'b0, V_PAT_OUT);
    endtask

`ifdef SHIFT_ROWS_INV_EN
    task automatic test_inverse();
        logic [127:0] x;
        logic [127:0] y;
        in_valid = 1'b1;
        inv      = 1'b1;
        in_data  = V_FIPS_OUT;
        cyc();
        chk("inv_fips", 1'b1, V_FIPS_IN);
        in_data  = V_IDX_IN;
        cyc();
        chk("inv_index", 1'b1, V_IDX_INV);
        inv      = 1'b0;
        in_data  = V_IDX_IN;
        cyc();
        chk("inv_sel_fwd", 1'b1, V_IDX_OUT);
        for (int i = 0; i < 4; i++) begin
            x        = {$urandom(), $urandom(), $urandom(), $urandom()};
            inv      = 1'b0;
            in_data  = x;
            cyc();
            y        = out_data;
            inv      = 1'b1;
            in_data  = y;
            cyc();
            chk("inv_roundtrip", 1'b1, x);
        end
        in_valid = 1'b0;
        inv      = 1'b0;
        cyc();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_forward();
        test_index();
        test_back_to_back();
        test_idle();
        test_reset_midstream();
`ifdef SHIFT_ROWS_INV_EN
        test_inverse();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
